// File: rtl/frontend_ctrl.sv
// frontend_ctrl: front-end sequencing controller for the out-of-order core.
// Drives IF_ID / ID_RN stall+flush and the PC stall, detects dispatch
// structural hazards at RN, emits redirect pulses on mispredict/exception
// and sequences rename-map recovery (ROB walk or arch-map restore + drain).
module frontend_ctrl #(
  parameter int WALK_PER_CYCLE = 2,
  parameter int ROB_IDX_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rn_valid,
  input  logic                 rn_needs_preg,
  input  logic                 rn_is_mem,
  input  logic                 rob_full,
  input  logic                 fl_empty,
  input  logic                 iq_full,
  input  logic                 lsq_full,
  input  logic                 rob_empty,
  input  logic                 mispredict_valid,
  input  logic [31:0]          mispredict_pc,
  input  logic [ROB_IDX_W:0]   mispredict_squash_cnt,
  input  logic                 except_valid,
  input  logic [31:0]          except_pc,
  output logic                 pc_stall,
  output logic                 stall_IF_ID,
  output logic                 flush_IF_ID,
  output logic                 stall_ID_RN,
  output logic                 flush_ID_RN,
  output logic                 rn_fire,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 walk_valid,
  output logic [ROB_IDX_W:0]   walk_cnt,
  output logic                 restore_arch,
  output logic [1:0]           state,
  output logic [31:0]          stall_cycles
);

  localparam int CNT_W = ROB_IDX_W + 1;
  localparam logic [CNT_W-1:0] WPC = CNT_W'(WALK_PER_CYCLE);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WALK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] walk_amt;
  logic             hazard;

  assign hazard = rn_valid & (rob_full | (rn_needs_preg & fl_empty) | iq_full |
                              (rn_is_mem & lsq_full));

  // Entries that can be rolled back this cycle: capped by the per-cycle width.
  assign walk_amt = (remaining_q < WPC) ? remaining_q : WPC;

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;

  // Output decode and next-state: exception > mispredict > state > hazard.
  // Redirect cycles drive flush only (never stall) so the pipeline registers,
  // which favour stall, really do flush.
  always_comb begin
    pc_stall       = 1'b0;
    stall_IF_ID    = 1'b0;
    flush_IF_ID    = 1'b0;
    stall_ID_RN    = 1'b0;
    flush_ID_RN    = 1'b0;
    rn_fire        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    walk_valid     = 1'b0;
    walk_cnt       = '0;
    restore_arch   = 1'b0;
    state_d        = state_q;
    remaining_d    = remaining_q;
    stall_cycles_d = stall_cycles_q;

    if (!rst) begin
      if (except_valid) begin
        flush_IF_ID    = 1'b1;
        flush_ID_RN    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = except_pc;
        restore_arch   = 1'b1;
        remaining_d    = '0;
        state_d        = ST_DRAIN;
      end else if (mispredict_valid && (state_q != ST_DRAIN)) begin
        flush_IF_ID    = 1'b1;
        flush_ID_RN    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mispredict_pc;
        remaining_d    = mispredict_squash_cnt;
        state_d        = (mispredict_squash_cnt != '0) ? ST_WALK : ST_RUN;
      end else begin
        case (state_q)
          ST_WALK: begin
            pc_stall    = 1'b1;
            stall_IF_ID = 1'b1;
            stall_ID_RN = 1'b1;
            walk_valid  = 1'b1;
            walk_cnt    = walk_amt;
            remaining_d = remaining_q - walk_amt;
            if (remaining_q <= WPC) begin
              state_d = ST_RUN;
            end
          end
          ST_DRAIN: begin
            pc_stall    = 1'b1;
            stall_IF_ID = 1'b1;
            stall_ID_RN = 1'b1;
            if (rob_empty) begin
              state_d = ST_RUN;
            end
          end
          default: begin
            // RUN, and recovery path for the unused encoding.
            state_d = ST_RUN;
            if (hazard) begin
              pc_stall       = 1'b1;
              stall_IF_ID    = 1'b1;
              stall_ID_RN    = 1'b1;
              stall_cycles_d = stall_cycles_q + 32'd1;
            end else begin
              rn_fire = rn_valid;
            end
          end
        endcase
      end
    end
  end

  // State, walk remainder and stall counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      remaining_q    <= '0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
